sm_debug_ctrl: RTL

//  Board-level run/step/scan controller for the sm_top core. It debounces the two

---
 rtl/sm_debug_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sm_debug_ctrl.sv
// Run/step/scan debug controller for sm_top: debounces the two board keys, sequences
// the RUN/STEP/SCAN modes and drives clkEnable, clkDivide and regAddr.
module sm_debug_ctrl #(
    parameter int unsigned DEBOUNCE_W = 20,
    parameter int unsigned SCAN_W     = 24,
    parameter logic [3:0]  DIV_RESET  = 4'b1000,
    parameter logic [4:0]  REG_RESET  = 5'd2
) (
    input  logic        clkIn,
    input  logic        rst_n,
    input  logic        keyMode,
    input  logic        keyAct,
    input  logic        cpuClk,
    input  logic [31:0] regData,
    output logic [3:0]  clkDivide,
    output logic        clkEnable,
    output logic [4:0]  regAddr,
    output logic [1:0]  mode,
    output logic [7:0]  led
);

    typedef enum logic [1:0] {ModeRun = 2'd0, ModeStep = 2'd1, ModeScan = 2'd2} mode_e;
    typedef enum logic {StepIdle = 1'b0, StepArm = 1'b1} step_e;

    // Bit 0 is the mode key, bit 1 the action key; all key flops idle released (1).
    logic [1:0]            key_s1, key_s2, key_deb, key_prev;
    logic [DEBOUNCE_W-1:0] db_cnt [2];
    logic [1:0]            press;
    logic                  press_mode, press_act;

    logic [2:0]            cpu_s;
    logic                  cpu_rise;

    mode_e                 mode_q;
    step_e                 step_q;
    logic                  freeze_q;
    logic [SCAN_W-1:0]     dwell_q;

    logic                  unused_data;

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            key_s1   <= '1;
            key_s2   <= '1;
            key_deb  <= '1;
            key_prev <= '1;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            key_s1   <= {keyAct, keyMode};
            key_s2   <= key_s1;
            key_prev <= key_deb;
            // Any return to the debounced level restarts the stability count.
            for (int i = 0; i < 2; i++) begin
                if (key_s2[i] == key_deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (&db_cnt[i]) begin
                    key_deb[i] <= key_s2[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press      = key_prev & ~key_deb;
    assign press_mode = press[0];
    assign press_act  = press[1] & ~press[0];

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) cpu_s <= '0;
        else        cpu_s <= {cpu_s[1:0], cpuClk};
    end

    assign cpu_rise = cpu_s[1] & ~cpu_s[2];

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= ModeRun;
            step_q    <= StepIdle;
            freeze_q  <= 1'b0;
            dwell_q   <= '0;
            clkEnable <= 1'b1;
            clkDivide <= DIV_RESET;
            regAddr   <= REG_RESET;
        end else if (press_mode) begin
            case (mode_q)
                ModeRun: begin
                    mode_q    <= ModeStep;
                    step_q    <= StepIdle;
                    clkEnable <= 1'b0;
                end
                ModeStep: begin
                    mode_q    <= ModeScan;
                    step_q    <= StepIdle;
                    dwell_q   <= '0;
                    freeze_q  <= 1'b0;
                    clkEnable <= 1'b1;
                end
                default: begin
                    mode_q    <= ModeRun;
                    clkEnable <= 1'b1;
                end
            endcase
        end else begin
            case (mode_q)
                ModeRun: begin
                    if (press_act) clkDivide <= clkDivide + 4'd1;
                end
                ModeStep: begin
                    if (step_q == StepArm) begin
                        if (cpu_rise) begin
                            step_q    <= StepIdle;
                            clkEnable <= 1'b0;
                        end
                    end else if (press_act) begin
                        step_q    <= StepArm;
                        clkEnable <= 1'b1;
                    end
                end
                ModeScan: begin
                    if (!freeze_q) begin
                        dwell_q <= dwell_q + 1'b1;
                        // Address 0 is skipped when the scan wraps.
                        if (&dwell_q) regAddr <= (regAddr == 5'd31) ? 5'd1 : regAddr + 5'd1;
                    end
                    if (press_act) freeze_q <= ~freeze_q;
                end
                default: begin
                    mode_q    <= ModeRun;
                    clkEnable <= 1'b1;
                end
            endcase
        end
    end

    assign mode        = mode_q;
    assign led         = {regData[6:0], cpuClk};
    assign unused_data = ^regData[31:7];

endmodule
